// File: rtl/sample_tap_buffer_pkg.sv
// Shared defaults, snapshot FSM encoding and a ceil-log2 helper for the tap buffer.
package sample_tap_buffer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 6;
  localparam int unsigned DEFAULT_SEL_W = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } snap_state_e;

  // Smallest number of bits able to index 'value' entries.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/sample_tap_buffer_delay_line.sv
// Sample delay line: DEPTH taps shifted by rxstrobe, saturating fill count, flush clear.
module tap_delay_line
  import sample_tap_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned SEL_W = DEFAULT_SEL_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rxstrobe,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       in_sample,
  output logic [DEPTH*WIDTH-1:0] taps,
  output logic [SEL_W:0]         fill
);

  localparam logic [SEL_W:0] FILL_MAX = (SEL_W+1)'(DEPTH);

  logic [WIDTH-1:0] tap_q [DEPTH];

  // Shift register; flush wins over a same-cycle strobe so that sample is dropped.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < int'(DEPTH); i++) tap_q[i] <= '0;
    end else if (rxstrobe) begin
      tap_q[0] <= in_sample;
      for (int i = 1; i < int'(DEPTH); i++) tap_q[i] <= tap_q[i-1];
    end
  end

  // Count of written taps, saturating at DEPTH.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      fill <= '0;
    end else if (rxstrobe && (fill != FILL_MAX)) begin
      fill <= fill + 1'b1;
    end
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_flatten
    assign taps[g*WIDTH +: WIDTH] = tap_q[g];
  end

endmodule

// File: rtl/sample_tap_buffer.sv
// Tap buffer top: delay line, live tap select and a snapshot streamer over valid/ready.
module sample_tap_buffer
  import sample_tap_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned SEL_W = DEFAULT_SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxstrobe,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_sample,
  output logic [WIDTH-1:0] out_sample,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] data,
  output logic [SEL_W:0]   fill,
  output logic             full,
  input  logic             snap_req,
  output logic             snap_busy,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             rd_last
);

  if ((SEL_W < clog2(DEPTH)) || (DEPTH < 2)) begin : g_param_check
    $error("sample_tap_buffer: need DEPTH >= 2 and 2**SEL_W >= DEPTH");
  end

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(DEPTH - 1);
  localparam logic [SEL_W:0]   FILL_MAX = (SEL_W+1)'(DEPTH);

  logic [DEPTH*WIDTH-1:0] taps;
  logic [WIDTH-1:0]       tap_w  [DEPTH];
  logic [WIDTH-1:0]       snap_q [DEPTH];
  snap_state_e            state, state_nxt;
  logic [SEL_W-1:0]       idx, idx_nxt;
  logic                   snap_load;

  tap_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_delay_line (
    .clk       (clk),
    .reset     (reset),
    .rxstrobe  (rxstrobe),
    .flush     (flush),
    .in_sample (in_sample),
    .taps      (taps),
    .fill      (fill)
  );

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_unpack
    assign tap_w[g] = taps[g*WIDTH +: WIDTH];
  end

  assign out_sample = tap_w[DEPTH-1];
  assign full       = (fill == FILL_MAX);

  // Live tap select; indices past the last tap read as zero.
  always_comb begin
    data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (sel == SEL_W'(i)) data = tap_w[i];
    end
  end

  // Snapshot FSM state and read index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Snapshot capture takes the pre-shift tap values of the request cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) snap_q[i] <= '0;
    end else if (snap_load) begin
      for (int i = 0; i < int'(DEPTH); i++) snap_q[i] <= tap_w[i];
    end
  end

  // Next-state and handshake outputs; requests outside IDLE are dropped.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    snap_load = 1'b0;
    snap_busy = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (snap_req) begin
          snap_load = 1'b1;
          idx_nxt   = '0;
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        snap_busy = 1'b1;
        rd_valid  = 1'b1;
        rd_last   = (idx == LAST_IDX);
        if (rd_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt = ST_IDLE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Streamed tap, held at zero outside a stream.
  always_comb begin
    rd_data = '0;
    if (state == ST_STREAM) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (idx == SEL_W'(i)) rd_data = snap_q[i];
      end
    end
  end

endmodule

// File: tb/tb_sample_tap_buffer.sv
// Bench for sample_tap_buffer: directed scenarios then random traffic against a queue model.
module tb_sample_tap_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 6;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             reset, rxstrobe, flush, snap_req, rd_ready;
  logic [WIDTH-1:0] in_sample;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] out_sample, data, rd_data;
  logic [SEL_W:0]   fill;
  logic             full, snap_busy, rd_valid, rd_last;

  always #5 clk = ~clk;

  sample_tap_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .rxstrobe   (rxstrobe),
    .flush      (flush),
    .in_sample  (in_sample),
    .out_sample (out_sample),
    .sel        (sel),
    .data       (data),
    .fill       (fill),
    .full       (full),
    .snap_req   (snap_req),
    .snap_busy  (snap_busy),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_last    (rd_last)
  );

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  // Model: line[0] is the newest sample; snapq is a frozen copy read out beat by beat.
  logic [WIDTH-1:0] line[$];
  logic [WIDTH-1:0] snapq[$];
  int  fill_m;
  bit  streaming;
  int  beat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear_line();
    line.delete();
    for (int i = 0; i < DEPTH; i++) line.push_back('0);
    fill_m = 0;
  endtask

  task automatic model_update();
    if (reset) begin
      model_clear_line();
      streaming = 0;
      beat = 0;
    end else begin
      if (!streaming) begin
        if (snap_req) begin
          snapq = line;
          streaming = 1;
          beat = 0;
        end
      end else if (rd_ready) begin
        beat++;
        if (beat == DEPTH) streaming = 0;
      end
      if (flush) begin
        model_clear_line();
      end else if (rxstrobe) begin
        line.push_front(in_sample);
        void'(line.pop_back());
        if (fill_m < DEPTH) fill_m++;
      end
    end
  endtask

  task automatic check_all();
    int s;
    logic [WIDTH-1:0] exp_data;
    s = int'(sel);
    exp_data = (s < DEPTH) ? line[s] : '0;
    chk("out_sample", 32'(out_sample), 32'(line[DEPTH-1]));
    chk("data", 32'(data), 32'(exp_data));
    chk("fill", 32'(fill), 32'(fill_m));
    chk("full", 32'(full), 32'(fill_m == DEPTH));
    chk("snap_busy", 32'(snap_busy), 32'(streaming));
    chk("rd_valid", 32'(rd_valid), 32'(streaming));
    chk("rd_last", 32'(rd_last), 32'(streaming && (beat == DEPTH - 1)));
    chk("rd_data", 32'(rd_data), streaming ? 32'(snapq[beat]) : 32'd0);
  endtask

  // Inputs are already driven after a negedge: check, clock, advance the model.
  task automatic step();
    #1;
    check_all();
    if (rd_valid && rd_ready) hs_count++;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input bit rs, input bit fl, input logic [WIDTH-1:0] din,
                       input bit sr, input bit rdy);
    reset = rs; rxstrobe = rs ? 1'b0 : 1'b1; flush = fl; in_sample = din;
    snap_req = sr; rd_ready = rdy;
  endtask

  task automatic idle_inputs();
    reset = 0; rxstrobe = 0; flush = 0; in_sample = '0; snap_req = 0; rd_ready = 0;
  endtask

  initial begin
    idle_inputs();
    sel = '0;
    reset = 1;
    model_clear_line();
    streaming = 0; beat = 0;
    @(negedge clk);
    @(posedge clk);
    model_update();
    @(negedge clk);
    reset = 0;

    // Reset state
    #1;
    chk("rst_out_sample", 32'(out_sample), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_snap_busy", 32'(snap_busy), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    check_all();

    // Fill with 0x11..0x66
    for (int k = 1; k <= 6; k++) begin
      drive(0, 0, WIDTH'(8'h11 * k), 0, 0);
      step();
      chk("fill_ramp", 32'(fill), 32'(k));
    end
    idle_inputs();
    #1;
    chk("fill6_out_sample", 32'(out_sample), 32'h11);
    chk("fill6_data_sel0", 32'(data), 32'h66);
    chk("fill6_full", 32'(full), 32'h1);

    // Overfill with 0x01..0x08, out-of-range select
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, WIDTH'(k), 0, 0);
      step();
    end
    idle_inputs();
    sel = 3'd7;
    #1;
    chk("sel7_data", 32'(data), 32'h0);
    chk("over_out_sample", 32'(out_sample), 32'h03);
    chk("over_fill", 32'(fill), 32'd6);
    step();

    // Flush beats a simultaneous strobe
    drive(0, 1, 8'hAA, 0, 0);
    step();
    idle_inputs();
    chk("flush_fill", 32'(fill), 32'h0);
    for (int s = 0; s < DEPTH; s++) begin
      sel = SEL_W'(s);
      #1;
      chk("flush_tap", 32'(data), 32'h0);
    end
    step();

    // Snapshot streamed while the line keeps shifting
    sel = '0;
    for (int k = 1; k <= 6; k++) begin
      drive(0, 0, WIDTH'(8'h11 * k), 0, 0);
      step();
    end
    drive(0, 0, WIDTH'($urandom), 1, 1);
    step();
    for (int k = 0; k < DEPTH; k++) begin
      drive(0, 0, WIDTH'($urandom), 0, 1);
      #1;
      chk("stream_rd_data", 32'(rd_data), 32'(8'h66 - 8'h11 * k));
      chk("stream_rd_last", 32'(rd_last), 32'(k == DEPTH - 1));
      step();
    end
    idle_inputs();
    #1;
    chk("stream_busy_fall", 32'(snap_busy), 32'h0);
    step();

    // Backpressure and ignored requests during a stream
    hs_count = 0;
    drive(0, 0, 8'h5A, 1, 0);
    rxstrobe = 0;
    step();
    begin
      bit pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int cyc = 0;
      while (rd_valid && cyc < 40) begin
        rxstrobe = 1; flush = 0; in_sample = WIDTH'($urandom);
        rd_ready = (cyc < 4) ? pattern[cyc] : 1'b1;
        snap_req = (cyc == 2 || rd_last) ? 1'b1 : 1'b0;
        step();
        cyc++;
      end
      chk("bp_timeout", 32'(cyc < 40), 32'h1);
    end
    idle_inputs();
    chk("bp_beats", 32'(hs_count), 32'd6);
    #1;
    chk("bp_idle_after", 32'(snap_busy), 32'h0);
    step();

    // Reset on the third beat discards the snapshot
    drive(0, 0, 8'h77, 1, 0);
    step();
    drive(0, 0, 8'h78, 0, 1);
    step();
    step();
    reset = 1; rxstrobe = 0; snap_req = 0;
    step();
    idle_inputs();
    #1;
    chk("rst_mid_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_mid_busy", 32'(snap_busy), 32'h0);
    chk("rst_mid_fill", 32'(fill), 32'h0);
    snap_req = 1; rd_ready = 1;
    step();
    snap_req = 0;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      chk("zero_stream", 32'(rd_data), 32'h0);
      step();
    end

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      rxstrobe  = ($urandom_range(0, 1) == 1);
      flush     = ($urandom_range(0, 19) == 0);
      in_sample = WIDTH'($urandom);
      snap_req  = ($urandom_range(0, 9) == 0);
      rd_ready  = ($urandom_range(0, 9) < 7);
      sel       = SEL_W'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
